// File: rtl/psa_io_regfile.sv
// PSA CPLD Z80 I/O register file: 8-register window, indirect sound-RAM port
// with optional address auto-increment, timer gate enables and timer chip select.
module psa_io_regfile #(
  parameter int          ADDR_W     = 11,
  parameter int          N_GATES    = 3,
  parameter logic [7:0]  BASE       = 8'h00,
  parameter logic [7:0]  TIMER_BASE = 8'h0C
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  input  logic                i_nIORQ,
  input  logic                i_nRD,
  input  logic                i_nWR,
  input  logic [7:0]          i_ZA,
  input  logic [7:0]          i_ZD,
  output logic [7:0]          o_ZD,
  output logic                o_ZD_OE,
  output logic                o_nTIMER_CS,
  output logic [N_GATES-1:0]  o_TIMER_GATE,
  output logic [ADDR_W-1:0]   o_RAM_A,
  output logic [7:0]          o_RAM_D,
  output logic                o_RAM_WE,
  input  logic [7:0]          i_RAM_Q
);

  localparam logic [2:0] OFF_DATA   = 3'd0;
  localparam logic [2:0] OFF_ADDR_LO = 3'd1;
  localparam logic [2:0] OFF_CTRL   = 3'd2;
  localparam logic [2:0] OFF_ADDR_HI = 3'd3;
  localparam logic [2:0] OFF_GATE   = 3'd4;
  localparam logic [2:0] OFF_STATUS = 3'd5;

  generate
    if (ADDR_W < 9 || ADDR_W > 16) begin : g_bad_addr_w
      $error("psa_io_regfile: ADDR_W must be 9..16");
    end
    if (N_GATES < 1 || N_GATES > 8) begin : g_bad_n_gates
      $error("psa_io_regfile: N_GATES must be 1..8");
    end
    if (BASE[2:0] != 3'b000) begin : g_bad_base
      $error("psa_io_regfile: BASE must be 8-aligned");
    end
    if (TIMER_BASE[1:0] != 2'b00) begin : g_bad_timer_base
      $error("psa_io_regfile: TIMER_BASE must be 4-aligned");
    end
    if (TIMER_BASE[7:3] == BASE[7:3]) begin : g_overlap
      $error("psa_io_regfile: TIMER_BASE window overlaps BASE window");
    end
  endgenerate

  logic                wr_raw, rd_raw;
  logic                in_win, in_timer;
  logic                wr_s1, wr_s2, wr_d, wr_arm;
  logic                rd_s1, rd_s2, rd_d, rd_arm;
  logic                rel_v1, rel_v2;
  logic                wr_rise, rd_rise, rd_fall;
  logic                wr_go;
  logic [2:0]          wr_off;
  logic [7:0]          wr_dat;
  logic                rd_act, rd_win;
  logic [2:0]          rd_off;
  logic [7:0]          data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          ctrl_q;
  logic [N_GATES-1:0]  gate_q;
  logic                ram_we_q;
  logic                inc_pend;
  logic                inc_set;
  logic                addr_wr;
  logic [15:0]         addr_ext;
  logic [ADDR_W-1:0]   addr_new;

  assign wr_raw   = !i_nIORQ && !i_nWR;
  assign rd_raw   = !i_nIORQ && !i_nRD;
  assign in_win   = (i_ZA[7:3] == BASE[7:3]);
  assign in_timer = (i_ZA[7:2] == TIMER_BASE[7:2]);

  assign o_ZD_OE     = rd_raw && in_win;
  assign o_nTIMER_CS = !((wr_raw || rd_raw) && in_timer);

  // A strobe already active when reset releases must go idle before it can
  // produce an edge; the arm flags wait for a synchronised low level.
  assign wr_rise = wr_s2 && !wr_d && wr_arm;
  assign rd_rise = rd_s2 && !rd_d && rd_arm;
  assign rd_fall = !rd_s2 && rd_d && rd_act;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      wr_s1  <= 1'b0;
      wr_s2  <= 1'b0;
      wr_d   <= 1'b0;
      rd_s1  <= 1'b0;
      rd_s2  <= 1'b0;
      rd_d   <= 1'b0;
      rel_v1 <= 1'b0;
      rel_v2 <= 1'b0;
      wr_arm <= 1'b0;
      rd_arm <= 1'b0;
    end else begin
      wr_s1  <= wr_raw;
      wr_s2  <= wr_s1;
      wr_d   <= wr_s2;
      rd_s1  <= rd_raw;
      rd_s2  <= rd_s1;
      rd_d   <= rd_s2;
      rel_v1 <= 1'b1;
      rel_v2 <= rel_v1;
      wr_arm <= wr_arm || (rel_v2 && !wr_s2);
      rd_arm <= rd_arm || (rel_v2 && !rd_s2);
    end
  end

  // Capture address and data at the write start edge; commit one cycle later.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      wr_go  <= 1'b0;
      wr_off <= 3'd0;
      wr_dat <= 8'h00;
      rd_act <= 1'b0;
      rd_win <= 1'b0;
      rd_off <= 3'd0;
    end else begin
      wr_go <= wr_rise && in_win;
      if (wr_rise) begin
        wr_off <= i_ZA[2:0];
        wr_dat <= i_ZD;
      end
      if (rd_rise) begin
        rd_act <= 1'b1;
        rd_win <= in_win;
        rd_off <= i_ZA[2:0];
      end else if (rd_fall) begin
        rd_act <= 1'b0;
      end
    end
  end

  assign addr_ext = 16'(addr_q);
  assign addr_wr  = wr_go && (wr_off == OFF_ADDR_LO || wr_off == OFF_ADDR_HI);
  assign inc_set  = ctrl_q[0] &&
                    ((wr_go && wr_off == OFF_DATA) ||
                     (rd_fall && rd_win && rd_off == OFF_DATA));

  always_comb begin
    addr_new = addr_q;
    if (wr_off == OFF_ADDR_LO) begin
      addr_new = ADDR_W'({addr_ext[15:8], wr_dat});
    end else begin
      addr_new = ADDR_W'({wr_dat, addr_ext[7:0]});
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      data_q   <= 8'h00;
      addr_q   <= '0;
      ctrl_q   <= 8'h00;
      gate_q   <= '0;
      ram_we_q <= 1'b0;
      inc_pend <= 1'b0;
    end else begin
      ram_we_q <= wr_go && (wr_off == OFF_DATA);
      inc_pend <= inc_set;
      if (wr_go) begin
        case (wr_off)
          OFF_DATA: data_q <= wr_dat;
          OFF_CTRL: ctrl_q <= wr_dat;
          OFF_GATE: gate_q <= wr_dat[N_GATES-1:0];
          default: ;
        endcase
      end
      // An explicit address write beats a pending increment.
      if (addr_wr) begin
        addr_q <= addr_new;
      end else if (inc_pend) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    o_ZD = 8'hFF;
    case (i_ZA[2:0])
      OFF_DATA:    o_ZD = i_RAM_Q;
      OFF_ADDR_LO: o_ZD = addr_ext[7:0];
      OFF_CTRL:    o_ZD = ctrl_q;
      OFF_ADDR_HI: o_ZD = addr_ext[15:8];
      OFF_GATE:    o_ZD = 8'(gate_q);
      OFF_STATUS:  o_ZD = {6'b000000, inc_pend, ram_we_q};
      default:     o_ZD = 8'hFF;
    endcase
  end

  assign o_TIMER_GATE = gate_q;
  assign o_RAM_A      = addr_q;
  assign o_RAM_D      = data_q;
  assign o_RAM_WE     = ram_we_q;

endmodule

// File: tb/tb_psa_io_regfile.sv
// Directed bench for psa_io_regfile with the default parameters
// (ADDR_W=11, N_GATES=3, BASE=8'h00, TIMER_BASE=8'h0C).
module tb_psa_io_regfile;

  logic        clk;
  logic        rst;
  logic        n_iorq, n_rd, n_wr;
  logic [7:0]  za, zd_in;
  logic [7:0]  zd_out;
  logic        zd_oe;
  logic        n_timer_cs;
  logic [2:0]  timer_gate;
  logic [10:0] ram_a;
  logic [7:0]  ram_d;
  logic        ram_we;
  logic [7:0]  ram_q;

  int errors = 0;
  int checks = 0;
  int we_cycles = 0;
  logic [10:0] we_addr[$];
  logic [7:0]  we_data[$];

  psa_io_regfile dut (
    .i_CLK        (clk),
    .i_RST        (rst),
    .i_nIORQ      (n_iorq),
    .i_nRD        (n_rd),
    .i_nWR        (n_wr),
    .i_ZA         (za),
    .i_ZD         (zd_in),
    .o_ZD         (zd_out),
    .o_ZD_OE      (zd_oe),
    .o_nTIMER_CS  (n_timer_cs),
    .o_TIMER_GATE (timer_gate),
    .o_RAM_A      (ram_a),
    .o_RAM_D      (ram_d),
    .o_RAM_WE     (ram_we),
    .i_RAM_Q      (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      we_cycles++;
      we_addr.push_back(ram_a);
      we_data.push_back(ram_d);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    za = a; zd_in = d; n_iorq = 1'b0; n_wr = 1'b0;
    idle(8);
    n_iorq = 1'b1; n_wr = 1'b1;
    idle(6);
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
    @(negedge clk);
    za = a; n_iorq = 1'b0; n_rd = 1'b0;
    idle(4);
    #1;
    d = zd_out; oe = zd_oe;
    @(negedge clk);
    n_iorq = 1'b1; n_rd = 1'b1;
    idle(6);
  endtask

  task automatic timer_access(input logic [7:0] a, input logic is_wr, output logic cs, output logic oe);
    @(negedge clk);
    za = a; zd_in = 8'h55; n_iorq = 1'b0;
    if (is_wr) n_wr = 1'b0; else n_rd = 1'b0;
    #1;
    cs = n_timer_cs; oe = zd_oe;
    idle(8);
    n_iorq = 1'b1; n_wr = 1'b1; n_rd = 1'b1;
    idle(6);
  endtask

  logic [7:0] rd_val;
  logic       rd_oe;
  logic       cs_v, oe_v;
  int         snap;

  initial begin
    rst = 1'b1; n_iorq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
    za = 8'h00; zd_in = 8'h00; ram_q = 8'h3C;
    idle(3);
    #1;
    chk("rst_gate", 32'(timer_gate), 32'h0);
    chk("rst_we", 32'(ram_we), 32'h0);
    chk("rst_ram_a", 32'(ram_a), 32'h0);
    chk("rst_ram_d", 32'(ram_d), 32'h0);
    chk("rst_oe", 32'(zd_oe), 32'h0);
    chk("rst_cs", 32'(n_timer_cs), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    idle(5);

    io_read(8'h05, rd_val, rd_oe);
    chk("idle_status", 32'(rd_val), 32'h00);
    chk("idle_oe", 32'(rd_oe), 32'h1);
    io_read(8'h06, rd_val, rd_oe);
    chk("idle_off6", 32'(rd_val), 32'hFF);
    io_read(8'h01, rd_val, rd_oe);
    chk("idle_addr_lo", 32'(rd_val), 32'h00);

    // Auto-increment DATA writes across the all-ones wrap
    io_write(8'h03, 8'h07);
    io_write(8'h01, 8'hFF);
    io_write(8'h02, 8'h01);
    io_write(8'h00, 8'hA5);
    io_write(8'h00, 8'h5A);
    chk("we_cycles", 32'(we_cycles), 32'd2);
    if (we_addr.size() == 2) begin
      chk("we0_addr", 32'(we_addr[0]), 32'h7FF);
      chk("we0_data", 32'(we_data[0]), 32'hA5);
      chk("we1_addr", 32'(we_addr[1]), 32'h000);
      chk("we1_data", 32'(we_data[1]), 32'h5A);
    end else begin
      chk("we_log_size", 32'(we_addr.size()), 32'd2);
    end
    io_read(8'h01, rd_val, rd_oe);
    chk("wrap_addr_lo", 32'(rd_val), 32'h01);
    io_read(8'h03, rd_val, rd_oe);
    chk("wrap_addr_hi", 32'(rd_val), 32'h00);
    io_read(8'h02, rd_val, rd_oe);
    chk("ctrl_read", 32'(rd_val), 32'h01);

    io_write(8'h04, 8'h01);
    chk("gate_01", 32'(timer_gate), 32'h1);
    io_write(8'h04, 8'h02);
    chk("gate_02", 32'(timer_gate), 32'h2);
    io_write(8'h04, 8'h04);
    chk("gate_04", 32'(timer_gate), 32'h4);
    io_write(8'h04, 8'hFF);
    chk("gate_ff", 32'(timer_gate), 32'h7);
    io_read(8'h04, rd_val, rd_oe);
    chk("gate_read", 32'(rd_val), 32'h07);
    io_write(8'h04, 8'h00);
    chk("gate_00", 32'(timer_gate), 32'h0);
    io_write(8'h04, 8'h05);

    for (int k = 0; k < 4; k++) begin
      timer_access(8'h0C + 8'(k), 1'b0, cs_v, oe_v);
      chk($sformatf("timer_rd_cs_%0d", k), 32'(cs_v), 32'h0);
      chk($sformatf("timer_rd_oe_%0d", k), 32'(oe_v), 32'h0);
    end
    snap = we_cycles;
    timer_access(8'h0E, 1'b1, cs_v, oe_v);
    chk("timer_wr_cs", 32'(cs_v), 32'h0);
    chk("timer_wr_we", 32'(we_cycles), 32'(snap));
    chk("timer_wr_addr", 32'(ram_a), 32'h001);
    chk("timer_wr_data", 32'(ram_d), 32'h5A);
    chk("timer_wr_gate", 32'(timer_gate), 32'h5);
    io_read(8'h02, rd_val, rd_oe);
    chk("timer_wr_ctrl", 32'(rd_val), 32'h01);
    timer_access(8'hFF, 1'b0, cs_v, oe_v);
    chk("outside_cs", 32'(cs_v), 32'h1);
    chk("outside_oe", 32'(oe_v), 32'h0);

    // DATA read: Z80 sees RAM at the old address, increment afterwards
    io_write(8'h03, 8'h00);
    io_write(8'h01, 8'h10);
    io_read(8'h00, rd_val, rd_oe);
    chk("data_rd_val", 32'(rd_val), 32'h3C);
    chk("data_rd_inc", 32'(ram_a), 32'h011);
    io_read(8'h01, rd_val, rd_oe);
    chk("data_rd_lo", 32'(rd_val), 32'h11);
    io_write(8'h02, 8'h00);
    io_write(8'h01, 8'h10);
    io_read(8'h00, rd_val, rd_oe);
    chk("noinc_rd_val", 32'(rd_val), 32'h3C);
    chk("noinc_addr", 32'(ram_a), 32'h010);

    // Reset during the write pulse; strobe still held when reset releases
    io_write(8'h02, 8'h01);
    io_write(8'h01, 8'h20);
    snap = we_cycles;
    @(negedge clk);
    za = 8'h00; zd_in = 8'h77; n_iorq = 1'b0; n_wr = 1'b0;
    for (int i = 0; i < 20 && ram_we !== 1'b1; i++) @(negedge clk);
    chk("midop_we_seen", 32'(ram_we), 32'h1);
    chk("midop_we_addr", 32'(ram_a), 32'h020);
    #1;
    rst = 1'b1;
    #1;
    chk("midop_we_drop", 32'(ram_we), 32'h0);
    chk("midop_addr", 32'(ram_a), 32'h000);
    chk("midop_data", 32'(ram_d), 32'h00);
    idle(3);
    rst = 1'b0;
    idle(8);
    n_iorq = 1'b1; n_wr = 1'b1;
    idle(10);
    chk("post_rst_we", 32'(we_cycles), 32'(snap + 1));
    chk("post_rst_addr", 32'(ram_a), 32'h000);
    chk("post_rst_data", 32'(ram_d), 32'h00);
    io_read(8'h05, rd_val, rd_oe);
    chk("post_rst_status", 32'(rd_val), 32'h00);
    io_read(8'h02, rd_val, rd_oe);
    chk("post_rst_ctrl", 32'(rd_val), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psa_io_regfile.md
# psa_io_regfile

Parametrised Z80 I/O register file for the PSA CPLD: decodes an 8-register window on the Z80 I/O bus, and drives an indirect-access port into the sound RAM with optional address auto-increment. It also drives N timer gate enables and the timer chip select. It succeeds the fixed 3-register PSA decoder, adding configurable RAM address width, gate count and window bases, a 2-flop strobe synchroniser, and a read-back status register.

## Interface
- ADDR_W, 11: sound RAM address width (9..16).
- N_GATES, 3: timer gate outputs (1..8).
- BASE, 8'h00: I/O window base; must be 8-aligned.
- TIMER_BASE, 8'h0C: timer chip window base; 4-aligned, must not overlap BASE..BASE+7 (elaboration error otherwise).

Ports:
- i_CLK  in  1  system clock.
- i_RST  in  1  reset, asynchronous, active-high.
- i_nIORQ  in  1  Z80 IORQ, async to i_CLK.
- i_nRD  in  1  Z80 RD, async.
- i_nWR  in  1  Z80 WR, async.
- i_ZA  in  8  Z80 I/O address A[7:0].
- i_ZD  in  8  Z80 write data.
- o_ZD  out  8  read data to Z80.
- o_ZD_OE  out  1  drive o_ZD onto Z80 bus.
- o_nTIMER_CS  out  1  timer chip select, active-low.
- o_TIMER_GATE  out  N_GATES  timer gate enables.
- o_RAM_A  out  ADDR_W  RAM address (= address register).
- o_RAM_D  out  8  RAM write data (= DATA register).
- o_RAM_WE  out  1  RAM write strobe, one-cycle pulse.
- i_RAM_Q  in  8  RAM read data at o_RAM_A.

## Operation
- Register offsets from BASE:
  - +0 DATA: write latches the value and writes RAM. Read returns i_RAM_Q.
  - +1 ADDR_LO: address bits [7:0].
  - +2 CTRL: bit0 AUTOINC; bits [7:1] stored, read back.
  - +3 ADDR_HI: address bits [ADDR_W-1:8]. Upper bits are ignored on write and read 0.
  - +4 GATE: bits [N_GATES-1:0] drive o_TIMER_GATE directly. Upper bits are ignored on write and read 0.
  - +5 STATUS (read-only): bit0 = o_RAM_WE, bit1 = increment pending, others 0.
  - +6, +7: reads return 8'hFF, writes are ignored.
- Address decode, combinational on raw bus:
  - o_ZD_OE = !i_nIORQ & !i_nRD & (i_ZA in BASE..BASE+7).
  - o_nTIMER_CS = 0 iff !i_nIORQ & (!i_nRD | !i_nWR) & (i_ZA in TIMER_BASE..TIMER_BASE+3).
  - Addresses outside both windows leave o_ZD_OE=0 and o_nTIMER_CS=1.
- o_ZD is a combinational mux of the register at offset i_ZA[2:0].
- Strobes: wr = !nIORQ & !nWR and rd = !nIORQ & !nRD, each passed through its own 2-flop synchroniser plus an edge-detect flop.
- Write start edge E: the cycle in which synchronised wr goes 0->1 with i_ZA in the window.
  - i_ZA and i_ZD are sampled at E. The Z80 holds them stable for the whole strobe.
- Read end edge R: the cycle in which synchronised rd goes 1->0 with the latched read offset = 0.
  - The read offset is latched at the read start edge.
- Auto-increment: address +1 modulo 2^ADDR_W (all-ones wraps to 0). Happens only when CTRL.AUTOINC=1.
- Simultaneous events:
  - An ADDR_LO/ADDR_HI write committing in the same cycle as a pending increment wins; the increment is dropped.
  - A CTRL write clearing AUTOINC does not cancel an increment already pending.
- Accesses to the timer window never touch register state.

## Timing
- Reset, asynchronous, any cycle:
  - DATA, ADDR, CTRL, GATE = 0.
  - o_TIMER_GATE=0, o_RAM_WE=0, o_RAM_A=0, o_RAM_D=0.
  - Synchroniser and edge flops cleared; pending pulse and increment cancelled.
- Reset is released synchronously into idle, with no spurious edge, even if a strobe is active at release.
- Write latency: the strobe asserts at the input; E occurs on the 3rd i_CLK rising edge. The target register updates at E+1.
- DATA write:
  - E+1: DATA updates, o_RAM_WE=1 for exactly one cycle, with o_RAM_A = pre-increment address.
  - E+2: address increments if AUTOINC.
- DATA read: the address increments at R+1 if AUTOINC, so the Z80 sampled i_RAM_Q at the old address.
- Strobe timing: a strobe shorter than 2 i_CLK periods may be missed. The Z80 clock is at most 1/3 of i_CLK, which is the guaranteed minimum.
- One access per strobe: a held strobe produces no repeated edge.

## Test plan
- Reset then idle: all outputs match reset values; reading +5 gives 8'h00, +6 gives 8'hFF, +1 gives 8'h00.
- ADDR_HI=8'h07, ADDR_LO=8'hFF, CTRL=8'h01, DATA writes 8'hA5 then 8'h5A:
  - Two o_RAM_WE pulses, at addresses 11'h7FF and 11'h000 (wrap).
  - Reading ADDR_LO then gives 8'h01.
- GATE writes of 8'h01, 8'h02, 8'h04, 8'hFF, 8'h00 (N_GATES=3): o_TIMER_GATE = 001, 010, 100, 111, 000; reading GATE after 8'hFF gives 8'h07.
- Reads of 8'h0C..8'h0F:
  - o_nTIMER_CS=0 and o_ZD_OE=0.
  - A write to 8'h0E leaves DATA, ADDR, CTRL and GATE unchanged.
  - A read of 8'hFF gives o_nTIMER_CS=1 and o_ZD_OE=0.
- AUTOINC=1, address 11'h010, i_RAM_Q=8'h3C, DATA read:
  - o_ZD=8'h3C during the strobe.
  - The address reads 11'h011 afterwards; with AUTOINC=0 it stays 11'h010.
- Reset mid-operation: i_RST asserted the cycle o_RAM_WE=1 during an AUTOINC DATA write. The pulse drops immediately, the address is 0, and no increment occurs after release.
